// File: rtl/stack_scan_ctrl.sv
// stack_scan_ctrl
// Scans a stack of layers by sending a command frame per layer and waiting for
// a matching acknowledge. A missing acknowledge is retried at increasing drive
// power. Once power is exhausted, the scan ends:
//   - in DONE if at least one layer answered (top of stack found);
//   - in FAIL if no layer answered.
//
// Optional feature: define STACK_SCAN_STATS_EN to add the retry_total output.
//
// Ports
//   div_8_clk    : sole clock, rising edge
//   rst          : synchronous active-high reset
//   start        : scan request, honoured only in IDLE/DONE/FAIL
//   max_layers   : expected layer count above the base (0 means 15)
//   rx_valid     : rx_data qualifier
//   rx_data      : acknowledge frame from the stack
//   tx_ready     : downstream accepts tx_data
//   tx_valid     : command frame valid
//   tx_data      : command frame, zero when tx_valid is low
//   busy         : scan in progress (SEND/WAIT/NEXT)
//   done         : scan finished
//   fail         : scan failed (no layer answered)
//   layer_count  : layers acknowledged so far
//   power_level  : current drive level
//   retry_total  : (STACK_SCAN_STATS_EN only) saturating timeout counter
module stack_scan_ctrl #(
    parameter int unsigned TIMEOUT = 20
) (
    input  logic        div_8_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  max_layers,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [3:0]  layer_count,
    output logic [3:0]  power_level
`ifdef STACK_SCAN_STATS_EN
    ,
    output logic [7:0]  retry_total
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        NEXT,
        DONE,
        FAIL
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cur_id_q, cur_id_d;
    logic [3:0]  power_level_q, power_level_d;
    logic [3:0]  layer_count_q, layer_count_d;
    logic [3:0]  max_q, max_d;
    logic [7:0]  timer_q, timer_d;
`ifdef STACK_SCAN_STATS_EN
    logic [7:0]  retry_total_q, retry_total_d;
`endif

    logic [3:0]  next_id;
    logic        ack_ok;
    logic        timeout_hit;
    logic        timeout_evt;

    // Don't-care nibbles of the acknowledge frame.
    logic        unused_rx_bits;
    assign unused_rx_bits = ^{rx_data[27:24], rx_data[19:16]};

    assign next_id     = cur_id_q + 4'd1;
    assign ack_ok      = rx_valid && (rx_data[31:28] == 4'h5) &&
                         (rx_data[15:0] == 16'hBEEF) && (rx_data[23:20] == next_id);
    assign timeout_hit = (timer_q == TIMER_LAST);

    always_comb begin
        state_d       = state_q;
        cur_id_d      = cur_id_q;
        power_level_d = power_level_q;
        layer_count_d = layer_count_q;
        max_d         = max_q;
        timer_d       = timer_q;
        timeout_evt   = 1'b0;

        case (state_q)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    cur_id_d      = 4'd1;
                    power_level_d = '0;
                    layer_count_d = '0;
                    timer_d       = '0;
                    max_d         = (max_layers == 4'd0) ? 4'd15 : max_layers;
                    state_d       = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // An acknowledge on the final timer cycle takes priority.
                if (ack_ok) begin
                    state_d = NEXT;
                end else if (timeout_hit) begin
                    timeout_evt = 1'b1;
                    timer_d     = '0;
                    if (power_level_q != 4'hF) begin
                        power_level_d = power_level_q + 4'd1;
                        state_d       = SEND;
                    end else if (layer_count_q != 4'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FAIL;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            NEXT: begin
                layer_count_d = layer_count_q + 4'd1;
                cur_id_d      = next_id;
                power_level_d = '0;
                state_d       = (layer_count_d == max_q) ? DONE : SEND;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef STACK_SCAN_STATS_EN
    always_comb begin
        retry_total_d = retry_total_q;
        if ((state_q == IDLE || state_q == DONE || state_q == FAIL) && start) begin
            retry_total_d = '0;
        end else if (timeout_evt && (retry_total_q != 8'hFF)) begin
            retry_total_d = retry_total_q + 8'd1;
        end
    end

    assign retry_total = retry_total_q;
`endif

    always_ff @(posedge div_8_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cur_id_q      <= '0;
            power_level_q <= '0;
            layer_count_q <= '0;
            max_q         <= '0;
            timer_q       <= '0;
`ifdef STACK_SCAN_STATS_EN
            retry_total_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cur_id_q      <= cur_id_d;
            power_level_q <= power_level_d;
            layer_count_q <= layer_count_d;
            max_q         <= max_d;
            timer_q       <= timer_d;
`ifdef STACK_SCAN_STATS_EN
            retry_total_q <= retry_total_d;
`endif
        end
    end

    always_comb begin
        tx_valid    = (state_q == SEND);
        tx_data     = tx_valid ? {4'hA, power_level_q, cur_id_q, next_id, 16'hBEEF} : '0;
        busy        = (state_q == SEND) || (state_q == WAIT) || (state_q == NEXT);
        done        = (state_q == DONE);
        fail        = (state_q == FAIL);
        layer_count = layer_count_q;
        power_level = power_level_q;
    end

endmodule

// File: tb/tb_stack_scan_ctrl.sv
// Self-checking bench for stack_scan_ctrl. Expected command frames are queued
// as each scan step is set up and compared by a monitor at every handshake.
module tb_stack_scan_ctrl;

    localparam int unsigned TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  max_layers;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        tx_ready;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        busy;
    logic        done;
    logic        fail;
    logic [3:0]  layer_count;
    logic [3:0]  power_level;
`ifdef STACK_SCAN_STATS_EN
    logic [7:0]  retry_total;
`endif

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    stack_scan_ctrl #(.TIMEOUT(TO)) dut (
        .div_8_clk   (clk),
        .rst         (rst),
        .start       (start),
        .max_layers  (max_layers),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .layer_count (layer_count),
        .power_level (power_level)
`ifdef STACK_SCAN_STATS_EN
        ,
        .retry_total (retry_total)
`endif
    );

    function automatic logic [31:0] frame(input logic [3:0] pl, input logic [3:0] id);
        logic [3:0] nid;
        nid = id + 4'd1;
        return {4'hA, pl, id, nid, 16'hBEEF};
    endfunction

    function automatic logic [31:0] ack(input logic [3:0] idn);
        return {4'h5, 4'($urandom), idn, 4'($urandom), 16'hBEEF};
    endfunction

    // Handshake monitor: tx_valid&&tx_ready seen at negedge is consumed at the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL tx_frame: got %h, expected none", tx_data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        tests_failed++;
                        $display("FAIL tx_frame: got %h, expected %h", tx_data, e);
                    end
                end
            end else if (!tx_valid) begin
                tests_run++;
                if (tx_data !== 32'h0) begin
                    tests_failed++;
                    $display("FAIL tx_idle_zero: got %h, expected 0", tx_data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] ml);
        start      = 1'b1;
        max_layers = ml;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_hs(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (tx_valid && tx_ready) ok = 1'b1;
            tick();
        end
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_handshake: got none, expected handshake within 60 cycles", name);
        end
    endtask

    task automatic send_ack(input logic [3:0] idn);
        rx_valid = 1'b1;
        rx_data  = ack(idn);
        tick();
        rx_valid = 1'b0;
        rx_data  = 32'h0;
    endtask

    // From a handshake, let WAIT expire and count cycles until the next SEND/DONE/FAIL.
    task automatic run_timeouts(input string name, input logic [3:0] id, input int n);
        for (int p = 0; p < n; p++) begin
            int cyc;
            exp_q.push_back(frame(4'(p), id));
            wait_hs(name);
            cyc = 0;
            while (!(tx_valid || done || fail) && cyc < 3 * TO) begin
                tick();
                cyc++;
            end
            tests_run++;
            if (cyc != TO) begin
                tests_failed++;
                $display("FAIL %s_timeout_len: got %0d, expected %0d (step %0d)", name, cyc, TO, p);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests_run++;
        if ({tx_valid, busy, done, fail, layer_count, power_level, tx_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b b=%b d=%b f=%b lc=%0d pl=%0d data=%h, expected all 0",
                     tx_valid, busy, done, fail, layer_count, power_level, tx_data);
        end
    endtask

    task automatic test_basic_scan();
        logic [31:0] bad;
        tx_ready = 1'b1;
        do_start(4'd3);
        for (int l = 1; l <= 3; l++) begin
            exp_q.push_back(frame(4'd0, 4'(l)));
            wait_hs("basic");
            case (l)
                1: begin bad = ack(4'(l + 2));  rx_valid = 1'b1; end
                2: begin bad = ack(4'(l + 1)); bad[31:28] = 4'h6; rx_valid = 1'b1; end
                default: begin bad = ack(4'(l + 1)); bad[15:0] = 16'hBEEE; rx_valid = 1'b1; end
            endcase
            rx_data = bad;
            tick();
            rx_valid = 1'b0;
            rx_data  = ack(4'(l + 1));
            tick();
            tests_run++;
            if (layer_count !== 4'(l - 1) || tx_valid !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL basic_bad_ack_ignored: got lc=%0d v=%b b=%b, expected lc=%0d v=0 b=1",
                         layer_count, tx_valid, busy, l - 1);
            end
            send_ack(4'(l + 1));
        end
        tick();
        tests_run++;
        if (done !== 1'b1 || layer_count !== 4'd3 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done: got done=%b lc=%0d busy=%b, expected done=1 lc=3 busy=0",
                     done, layer_count, busy);
        end
    endtask

    task automatic test_timeout_fail();
        tx_ready = 1'b1;
        do_start(4'd3);
        run_timeouts("fail", 4'd1, 16);
        tests_run++;
        if (fail !== 1'b1 || done !== 1'b0 || layer_count !== 4'd0 || power_level !== 4'd15) begin
            tests_failed++;
            $display("FAIL fail_end: got fail=%b done=%b lc=%0d pl=%0d, expected fail=1 done=0 lc=0 pl=15",
                     fail, done, layer_count, power_level);
        end
`ifdef STACK_SCAN_STATS_EN
        tests_run++;
        if (retry_total !== 8'd16) begin
            tests_failed++;
            $display("FAIL fail_retry_total: got %0d, expected 16", retry_total);
        end
`endif
    endtask

    task automatic test_top_of_stack();
        tx_ready = 1'b1;
        do_start(4'd0);
        for (int l = 1; l <= 2; l++) begin
            exp_q.push_back(frame(4'd0, 4'(l)));
            wait_hs("top");
            send_ack(4'(l + 1));
        end
        run_timeouts("top", 4'd3, 16);
        tests_run++;
        if (done !== 1'b1 || fail !== 1'b0 || layer_count !== 4'd2 || power_level !== 4'd15) begin
            tests_failed++;
            $display("FAIL top_end: got done=%b fail=%b lc=%0d pl=%0d, expected done=1 fail=0 lc=2 pl=15",
                     done, fail, layer_count, power_level);
        end
`ifdef STACK_SCAN_STATS_EN
        tests_run++;
        if (retry_total !== 8'd16) begin
            tests_failed++;
            $display("FAIL top_retry_total: got %0d, expected 16", retry_total);
        end
`endif
    endtask

    task automatic test_late_ack();
        tx_ready = 1'b1;
        do_start(4'd2);
        exp_q.push_back(frame(4'd0, 4'd1));
        wait_hs("late");
        for (int i = 0; i < TO - 1; i++) tick();
        send_ack(4'd2);
        tick();
        tests_run++;
        if (layer_count !== 4'd1 || power_level !== 4'd0 || tx_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL late_ack_next: got lc=%0d pl=%0d v=%b, expected lc=1 pl=0 v=1",
                     layer_count, power_level, tx_valid);
        end
        exp_q.push_back(frame(4'd0, 4'd2));
        wait_hs("late");
        send_ack(4'd3);
        tick();
        tests_run++;
        if (done !== 1'b1 || layer_count !== 4'd2) begin
            tests_failed++;
            $display("FAIL late_done: got done=%b lc=%0d, expected done=1 lc=2", done, layer_count);
        end
    endtask

    task automatic test_stall();
        logic [31:0] want;
        tx_ready = 1'b0;
        do_start(4'd1);
        want = frame(4'd0, 4'd1);
        for (int i = 0; i < 7; i++) begin
            tests_run++;
            if (tx_valid !== 1'b1 || tx_data !== want || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold: got v=%b data=%h b=%b, expected v=1 data=%h b=1",
                         tx_valid, tx_data, busy, want);
            end
            if (i == 3) begin
                start      = 1'b1;
                max_layers = 4'd5;
            end
            tick();
            start = 1'b0;
        end
        tx_ready = 1'b1;
        run_timeouts("stall", 4'd1, 1);
        exp_q.push_back(frame(4'd1, 4'd1));
        wait_hs("stall");
        send_ack(4'd2);
        tick();
        tests_run++;
        if (done !== 1'b1 || layer_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL stall_done: got done=%b lc=%0d, expected done=1 lc=1", done, layer_count);
        end
    endtask

    task automatic test_restart_and_reset();
        tx_ready = 1'b1;
        do_start(4'd2);
        tests_run++;
        if (layer_count !== 4'd0 || power_level !== 4'd0 || done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_clear: got lc=%0d pl=%0d done=%b busy=%b, expected lc=0 pl=0 done=0 busy=1",
                     layer_count, power_level, done, busy);
        end
        exp_q.push_back(frame(4'd0, 4'd1));
        wait_hs("rst_mid");
        tick();
        tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tests_run++;
        if ({tx_valid, busy, done, fail, layer_count, power_level, tx_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_wait: got v=%b b=%b d=%b f=%b lc=%0d pl=%0d, expected all 0",
                     tx_valid, busy, done, fail, layer_count, power_level);
        end
        tick();
        tests_run++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_over_start: got v=%b b=%b, expected v=0 b=0", tx_valid, busy);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        max_layers = 4'd0;
        rx_valid   = 1'b0;
        rx_data    = 32'h0;
        tx_ready   = 1'b0;
        test_reset();
        test_basic_scan();
        test_timeout_fail();
        test_top_of_stack();
        test_late_ack();
        test_stall();
        test_restart_and_reset();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d frames outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
